pool_argmax: RTL
================

# pool_argmax

Classifier head directly downstream of the linear layer. It consumes the MATRIX_SIZE×MATRIX_SIZE signed logit matrix, sums each class column over all token rows (global sum-pooling), and selects the class with the largest sum. It produces a registered class index and score plus a one-cycle `done` pulse, and is the final stage of the ECG inference path.

## Interface
- `MATRIX_SIZE`, 16, rows (tokens) and columns of the input matrix
- `DATA_SIZE`, 8, signed element width
- `NUM_CLASSES`, 5, number of leading columns treated as class logits; 2 ≤ NUM_CLASSES ≤ MATRIX_SIZE (elaboration error otherwise)
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high
- `start` input 1: begin classification; sampled only in IDLE
- `in_matrix` input signed [DATA_SIZE-1:0] [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1]: logits from linear layer
- `busy` output 1: high in every state except IDLE
- `done` output 1: one-cycle pulse when result is valid
- `class_id` output [$clog2(NUM_CLASSES)-1:0]: winning column index
- `class_score` output signed [ACC_W-1:0]: winning column sum, ACC_W = DATA_SIZE + $clog2(MATRIX_SIZE)

## Operation
- FSM states: IDLE → ACCUM → SCAN → DONE → IDLE.
- IDLE:
  - `start`=1 at an edge: clear acc[0:NUM_CLASSES-1] to 0, row counter r=0, go to ACCUM.
  - `start`=0: stay in IDLE.
- ACCUM, one row per cycle:
  - acc[c] += sign_extend(in_matrix[r][c]) for c < NUM_CLASSES; columns ≥ NUM_CLASSES ignored.
  - When r = MATRIX_SIZE-1, go to SCAN with best=acc[0], idx=0, k=1.
- SCAN, one candidate per cycle:
  - If acc[k] > best (strict signed compare), then best=acc[k], idx=k.
  - When k = NUM_CLASSES-1, go to DONE.
  - Ties keep the lower index.
- DONE: `class_id`=idx, `class_score`=best, `done`=1 for this single cycle; next state IDLE.
- Arithmetic: ACC_W bits, so no overflow is possible (16×−128 = −2048 fits 12 bits). No saturation, no rounding.
- `in_matrix` must be held stable by upstream from the `start` cycle through the last ACCUM cycle. The block does not latch the matrix.
- `start` is ignored while `busy`=1; it is not queued.
- `class_id` and `class_score` hold their value until the next DONE.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `class_id`=0, `class_score`=0; accumulators and counters are 0.
- Reset asserted in any state returns the block to IDLE on the next edge. An in-flight result is discarded and no `done` is emitted.
- Reset takes priority over `start` on the same edge.
- Latency: `start` high in cycle 0 → ACCUM in cycles 1..MATRIX_SIZE → SCAN for NUM_CLASSES-1 cycles → `done` in cycle MATRIX_SIZE+NUM_CLASSES. Default is cycle 21.
- `start` may be reasserted in the cycle after DONE (block is in IDLE). Back-to-back throughput is one result per MATRIX_SIZE+NUM_CLASSES+1 cycles.
- `start` asserted in the DONE cycle is ignored.
- Upstream `done` from the linear layer connects directly to `start`.

## Structure
- Shared package `classifier_pkg`:
  - MATRIX_SIZE, DATA_SIZE, NUM_CLASSES, ACC_W constants.
  - `pool_state_t` enum {IDLE, ACCUM, SCAN, DONE}.
- One natural sub-module: `column_accumulator`, a NUM_CLASSES-wide signed add-and-hold bank with `clear` and `en` inputs. The FSM, counters and argmax compare stay in `pool_argmax`.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- Reset, then idle for 5 cycles → `busy`=0, `done`=0, `class_id`=0, `class_score`=0.
- All elements 1 except column 3 = 2 in every row; pulse `start` → `done` exactly at cycle 21, `class_id`=3, `class_score`=32, `busy` high cycles 1..21.
- Columns 1 and 4 both 5 in every row, others 0 → `class_id`=1, `class_score`=80 (tie resolves to lower index).
- All elements −128 → `class_id`=0, `class_score`=−2048 (no overflow).
- Column 4 = 127 and columns 0..3 = −1 only in rows ≥ 8 (otherwise 0); pulse `start` again at cycle 5 → second `start` ignored, single `done` at cycle 21, `class_id`=4, `class_score`=1016.
- Assert `reset` at cycle 10 mid-ACCUM → no `done` at cycle 21, outputs 0. A new `start` after reset gives the correct result 21 cycles later.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared constants and FSM state type for the ECG classifier head.
package classifier_pkg;

  localparam int unsigned MATRIX_SIZE = 16;
  localparam int unsigned DATA_SIZE   = 8;
  localparam int unsigned NUM_CLASSES = 5;
  localparam int unsigned ACC_W       = DATA_SIZE + $clog2(MATRIX_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCAN,
    DONE
  } pool_state_t;

endpackage

// File: rtl/column_accumulator.sv
// Bank of signed add-and-hold accumulators, one per class column.
module column_accumulator #(
  parameter int unsigned NUM_CLASSES = 5,
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned ACC_W       = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [DATA_SIZE-1:0] row_in [NUM_CLASSES],
  output logic signed [ACC_W-1:0]     acc    [NUM_CLASSES]
);

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (reset || clear) begin
        acc[c] <= '0;
      end else if (en) begin
        acc[c] <= acc[c] + {{(ACC_W-DATA_SIZE){row_in[c][DATA_SIZE-1]}}, row_in[c]};
      end
    end
  end

endmodule

// File: rtl/pool_argmax.sv
// Global sum-pooling over token rows followed by a sequential argmax over class columns.
module pool_argmax
  import classifier_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = classifier_pkg::MATRIX_SIZE,
  parameter int unsigned DATA_SIZE   = classifier_pkg::DATA_SIZE,
  parameter int unsigned NUM_CLASSES = classifier_pkg::NUM_CLASSES,
  localparam int unsigned ACC_W      = DATA_SIZE + $clog2(MATRIX_SIZE),
  localparam int unsigned CID_W      = $clog2(NUM_CLASSES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [DATA_SIZE-1:0] in_matrix [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  output logic                        busy,
  output logic                        done,
  output logic [CID_W-1:0]            class_id,
  output logic signed [ACC_W-1:0]     class_score
);

  localparam int unsigned ROW_W = $clog2(MATRIX_SIZE);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_SIZE - 1);
  localparam logic [CID_W-1:0] LAST_K   = CID_W'(NUM_CLASSES - 1);

  if (NUM_CLASSES < 2 || NUM_CLASSES > MATRIX_SIZE) begin : gen_bad_classes
    $error("NUM_CLASSES must satisfy 2 <= NUM_CLASSES <= MATRIX_SIZE");
  end

  pool_state_t              state_q;
  logic [ROW_W-1:0]         row_q;
  logic [CID_W-1:0]         k_q;
  logic [CID_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  best_q;

  logic signed [DATA_SIZE-1:0] row_vals [NUM_CLASSES];
  logic signed [ACC_W-1:0]     acc      [NUM_CLASSES];
  logic signed [ACC_W-1:0]     cand;
  logic signed [ACC_W-1:0]     scan_best;
  logic [CID_W-1:0]            scan_idx;
  logic signed [ACC_W-1:0]     first_sum;
  logic                        unused_cols;

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      row_vals[c] = in_matrix[row_q][c];
    end
  end

  // Columns beyond the class logits are deliberately dropped.
  always_comb begin
    unused_cols = 1'b0;
    for (int r = 0; r < MATRIX_SIZE; r++) begin
      for (int c = NUM_CLASSES; c < MATRIX_SIZE; c++) begin
        unused_cols = unused_cols ^ (^in_matrix[r][c]);
      end
    end
  end

  column_accumulator #(
    .NUM_CLASSES (NUM_CLASSES),
    .DATA_SIZE   (DATA_SIZE),
    .ACC_W       (ACC_W)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == IDLE) && start),
    .en     (state_q == ACCUM),
    .row_in (row_vals),
    .acc    (acc)
  );

  // The bank only settles after the last row's edge, so seed best with column 0's final sum.
  always_comb begin
    first_sum = acc[0] + {{(ACC_W-DATA_SIZE){row_vals[0][DATA_SIZE-1]}}, row_vals[0]};
    cand      = acc[k_q];
    if (cand > best_q) begin
      scan_best = cand;
      scan_idx  = k_q;
    end else begin
      scan_best = best_q;
      scan_idx  = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      class_id    <= '0;
      class_score <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCUM;
            row_q   <= '0;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (row_q == LAST_ROW) begin
            state_q <= SCAN;
            best_q  <= first_sum;
            idx_q   <= '0;
            k_q     <= CID_W'(1);
          end else begin
            row_q <= row_q + ROW_W'(1);
          end
        end
        SCAN: begin
          best_q <= scan_best;
          idx_q  <= scan_idx;
          if (k_q == LAST_K) begin
            state_q     <= DONE;
            done        <= 1'b1;
            class_id    <= scan_idx;
            class_score <= scan_best;
          end else begin
            k_q <= k_q + CID_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
